// File: rtl/bcd_pkg.sv
// Shared types and sizing for the SPI-temperature to packed-BCD converter.
package bcd_pkg;

    localparam int          SPI_WIDTH   = 24;
    localparam int          BIN_WIDTH   = 16;
    localparam int          FIELD_LSB   = 8;
    localparam int          NUM_DIGITS  = 4;
    localparam int          SHIFT_CNT_W = $clog2(BIN_WIDTH);
    localparam logic [15:0] BCD_MAX     = 16'h9999;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: bias a BCD digit by 3 when it is 5 or more,
// so the following left shift carries cleanly into the next digit.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bcd_value_register.sv
// Captures the temperature field of an SPI word on a trigger rising edge and
// converts it to packed BCD one bit per clock, saturating at all-nines.
module bcd_value_register
    import bcd_pkg::*;
#(
    parameter int BIN_WIDTH  = bcd_pkg::BIN_WIDTH,
    parameter int FIELD_LSB  = bcd_pkg::FIELD_LSB,
    parameter int NUM_DIGITS = bcd_pkg::NUM_DIGITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    new_data_triger,
    input  logic [SPI_WIDTH-1:0]    spi_data,
    output logic [4*NUM_DIGITS-1:0] bcd_values,
    output logic                    bcd_valid,
    output logic                    busy,
    output logic                    overflow
);

    localparam int CNT_W = $clog2(BIN_WIDTH);

    state_t                        state;
    logic                          trig_q;
    logic                          start;
    logic [CNT_W-1:0]              cnt;
    logic [BIN_WIDTH-1:0]          bin_sr;
    // One extra scratch digit catches values that do not fit the display.
    logic [NUM_DIGITS:0][3:0]      scratch;
    logic [NUM_DIGITS:0][3:0]      adj;
    logic [BIN_WIDTH-1:0]          field;
    logic                          unused_bits;

    assign field       = spi_data[FIELD_LSB+BIN_WIDTH-1:FIELD_LSB];
    assign unused_bits = ^spi_data[FIELD_LSB-1:0];
    assign start       = new_data_triger & ~trig_q;

    for (genvar d = 0; d <= NUM_DIGITS; d++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch[d]),
            .dout (adj[d])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            trig_q     <= 1'b0;
            cnt        <= '0;
            bin_sr     <= '0;
            scratch    <= '0;
            bcd_values <= '0;
            bcd_valid  <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            trig_q    <= new_data_triger;
            bcd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr  <= field;
                        scratch <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scratch, bin_sr} <= {adj, bin_sr} << 1;
                    cnt               <= cnt + 1'b1;
                    if (cnt == CNT_W'(BIN_WIDTH - 1))
                        state <= DONE;
                end
                DONE: begin
                    // A non-zero top digit means the field exceeded the display range.
                    if (scratch[NUM_DIGITS] != 4'd0) begin
                        bcd_values <= {NUM_DIGITS{4'h9}};
                        overflow   <= 1'b1;
                    end else begin
                        bcd_values <= scratch[NUM_DIGITS-1:0];
                        overflow   <= 1'b0;
                    end
                    bcd_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_value_register.sv
// Directed and random conversions checked against a decimal-arithmetic model.
module tb_bcd_value_register;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        new_data_triger = 1'b0;
    logic [23:0] spi_data = 24'h0;
    logic [15:0] bcd_values;
    logic        bcd_valid;
    logic        busy;
    logic        overflow;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] ref_val = 16'h0;
    logic        ref_ovf = 1'b0;

    always #5 clk = ~clk;

    bcd_value_register dut (
        .clk             (clk),
        .rst             (rst),
        .new_data_triger (new_data_triger),
        .spi_data        (spi_data),
        .bcd_values      (bcd_values),
        .bcd_valid       (bcd_valid),
        .busy            (busy),
        .overflow        (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected result from plain decimal arithmetic on bits [23:8].
    function automatic logic [16:0] model(input logic [23:0] d);
        int v;
        v = int'(d[23:8]);
        if (v > 9999) return {1'b1, 16'h9999};
        return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // One conversion. glitch_at / rst_at: cycle after the start edge at which a
    // second trigger edge (with new data) or a reset is applied; 0 = none.
    // pre_rst: trigger is already high while reset is held and then released.
    task automatic conv(input logic [23:0] d, input int glitch_at, input int rst_at,
                        input bit pre_rst);
        logic [16:0] m;
        int          n;
        bit          seen;
        bit          extra;
        m = model(d);
        @(negedge clk);
        spi_data        = d;
        new_data_triger = 1'b1;
        if (pre_rst) begin
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            ref_val = 16'h0;
            ref_ovf = 1'b0;
        end
        @(posedge clk);                      // start-detect edge
        @(negedge clk);
        new_data_triger = 1'b0;
        spi_data        = 24'($urandom);     // must not affect the result
        chk("busy_start", 32'(busy), 32'd1);
        seen = 0;
        n    = 0;
        for (int i = 1; i <= 25 && !seen; i++) begin
            if (i == glitch_at) begin
                new_data_triger = 1'b1;
                spi_data        = 24'h000500;
            end
            if (i == rst_at) rst = 1'b1;
            @(posedge clk);
            #1;
            if (i == rst_at) begin
                chk("rst_values", 32'(bcd_values), 32'h0);
                chk("rst_busy", {30'd0, busy, bcd_valid}, 32'd0);
                chk("rst_ovf", 32'(overflow), 32'd0);
                ref_val = 16'h0;
                ref_ovf = 1'b0;
                @(negedge clk);
                rst   = 1'b0;
                extra = 0;
                for (int k = 0; k < 20; k++) begin
                    @(posedge clk);
                    #1;
                    if (bcd_valid || busy) extra = 1;
                end
                chk("rst_no_valid", 32'(extra), 32'd0);
                return;
            end
            if (bcd_valid) begin
                seen = 1;
                n    = i;
            end else if (i == 8 || i == 16) begin
                chk("hold_partial", 32'(bcd_values), 32'(ref_val));
            end
            @(negedge clk);
        end
        new_data_triger = 1'b0;
        chk("latency", 32'(n), 32'd17);
        chk("value", 32'(bcd_values), 32'(m[15:0]));
        chk("overflow", 32'(overflow), 32'(m[16]));
        chk("busy_done", 32'(busy), 32'd0);
        ref_val = m[15:0];
        ref_ovf = m[16];
        extra   = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bcd_valid || busy || bcd_values !== ref_val) extra = 1;
        end
        chk("pulse_hold", 32'(extra), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_values", 32'(bcd_values), 32'h0);
        chk("reset_flags", {29'd0, bcd_valid, busy, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_flags", {29'd0, bcd_valid, busy, overflow}, 32'd0);

        conv(24'h006464, 0, 0, 0);           // 100
        conv(24'h000000, 0, 0, 0);           // 0
        conv(24'h004444, 0, 0, 0);           // 68
        conv(24'h270F5A, 0, 0, 0);           // 9999
        conv(24'h2710A5, 0, 0, 0);           // 10000 saturates
        conv(24'h0003C3, 0, 0, 0);           // back in range clears overflow
        conv(24'hFFFFFF, 0, 0, 0);           // 65535 saturates
        conv(24'h006464, 5, 0, 0);           // second edge mid-conversion ignored
        conv(24'h1234AB, 17, 0, 0);          // edge during DONE cycle ignored
        conv(24'h004444, 0, 8, 0);           // reset aborts
        conv(24'h0D8000, 0, 0, 0);           // 3456 after abort
        conv(24'h0929FF, 0, 0, 1);           // trigger high through reset release
        for (int r = 0; r < 10; r++)
            conv(24'($urandom), 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
